// File: rtl/exec_sequencer.sv
// exec_sequencer: multi-cycle instruction sequencer that owns the program
// counter and turns the combinational decoder's enables into one-cycle strobes.
// Each instruction runs FETCH -> EXEC, plus MEM_WAIT cycles for loads and one SWAP2 cycle for swaps.
// A Req/Ack handshake starts a program and reports when it has finished.
// Optional build macro: SEQ_PERF_CNT_EN adds a saturating retired-instruction counter.
module exec_sequencer #(
    parameter int          PC_W     = 10,
    parameter int unsigned START_PC = 0,
    parameter int          MEM_LAT  = 1
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Req,
    output logic            Ack,
    input  logic [PC_W-1:0] prog_end,
    input  logic            RegWrite_in,
    input  logic            MemWrite_in,
    input  logic            doSWAP_in,
    input  logic            load_in,
    input  logic            jump_en,
    input  logic [PC_W-1:0] target,
    output logic [PC_W-1:0] pc,
    output logic            instr_valid,
    output logic            reg_we,
    output logic            swap_phase,
    output logic            mem_we,
`ifdef SEQ_PERF_CNT_EN
    output logic [15:0]     retired,
`endif
    output logic            busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_MEM_WAIT,
        S_SWAP2,
        S_DONE
    } state_t;

    localparam logic [PC_W-1:0] START_PC_V = PC_W'(START_PC);
    localparam logic [2:0]      LAT_V      = 3'(MEM_LAT);
    localparam bit              HAS_WAIT   = (MEM_LAT > 0);

    state_t          r_state;
    logic [PC_W-1:0] r_pc;
    logic [2:0]      r_wait_cnt;
    logic            r_jump;
    logic [PC_W-1:0] r_target;
    logic            r_reg_we;
    logic            r_mem_we;
    logic            r_swap_phase;

    logic            w_jump;
    logic [PC_W-1:0] w_target;
    logic [PC_W-1:0] w_next;
    logic            w_done;
    logic            w_update;

    // Next-PC selection: in EXEC the branch inputs are live; later phases
    // (MEM_WAIT, SWAP2) use the copy captured in EXEC, since the decoder
    // outputs are no longer meaningful by then.
    always_comb begin
        w_jump   = (r_state == S_EXEC) ? jump_en : r_jump;
        w_target = (r_state == S_EXEC) ? target  : r_target;
        w_next   = w_jump ? w_target : (r_pc + PC_W'(1));
        w_done   = (w_next == prog_end);
    end

    // Marks the cycle in which the current instruction retires and the PC advances.
    always_comb begin
        w_update = 1'b0;
        case (r_state)
            S_EXEC:     w_update = !(load_in && HAS_WAIT) && !doSWAP_in;
            S_MEM_WAIT: w_update = (r_wait_cnt <= 3'd1);
            S_SWAP2:    w_update = 1'b1;
            default:    w_update = 1'b0;
        endcase
    end

    // Main sequencer FSM: state, PC, wait counter and the registered write strobes.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state      <= S_IDLE;
            r_pc         <= START_PC_V;
            r_wait_cnt   <= '0;
            r_jump       <= 1'b0;
            r_target     <= '0;
            r_reg_we     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_swap_phase <= 1'b0;
        end else begin
            r_reg_we     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_swap_phase <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (Req) begin
                        r_pc    <= START_PC_V;
                        r_state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    r_jump   <= jump_en;
                    r_target <= target;
                    if (load_in && HAS_WAIT) begin
                        r_wait_cnt <= LAT_V;
                        r_state    <= S_MEM_WAIT;
                    end else if (doSWAP_in) begin
                        r_reg_we     <= 1'b1;
                        r_swap_phase <= 1'b0;
                        r_state      <= S_SWAP2;
                    end else begin
                        r_reg_we <= RegWrite_in;
                        r_mem_we <= MemWrite_in;
                    end
                end
                S_MEM_WAIT: begin
                    r_wait_cnt <= r_wait_cnt - 3'd1;
                    if (r_wait_cnt <= 3'd1) begin
                        r_reg_we <= 1'b1;
                    end
                end
                S_SWAP2: begin
                    r_reg_we     <= 1'b1;
                    r_swap_phase <= 1'b1;
                end
                S_DONE: begin
                    if (!Req) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
            if (w_update) begin
                r_pc    <= w_next;
                r_state <= w_done ? S_DONE : S_FETCH;
            end
        end
    end

`ifdef SEQ_PERF_CNT_EN
    logic [15:0] r_retired;

    // Retired-instruction counter: one per PC update, saturating, cleared when a program starts.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_retired <= '0;
        end else if (r_state == S_IDLE && Req) begin
            r_retired <= '0;
        end else if (w_update && r_retired != 16'hFFFF) begin
            r_retired <= r_retired + 16'd1;
        end
    end

    assign retired = r_retired;
`endif

    assign pc          = r_pc;
    assign reg_we      = r_reg_we;
    assign mem_we      = r_mem_we;
    assign swap_phase  = r_swap_phase;
    assign instr_valid = (r_state == S_EXEC);
    assign Ack         = (r_state == S_DONE);
    assign busy        = (r_state != S_IDLE) && (r_state != S_DONE);

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed testbench for exec_sequencer (PC_W=10, START_PC=0, MEM_LAT=3).
// With SEQ_PERF_CNT_EN defined it also exercises the retired counter.
module tb_exec_sequencer;

    logic        Clk;
    logic        Reset;
    logic        Req;
    logic        Ack;
    logic [9:0]  prog_end;
    logic        RegWrite_in;
    logic        MemWrite_in;
    logic        doSWAP_in;
    logic        load_in;
    logic        jump_en;
    logic [9:0]  target;
    logic [9:0]  pc;
    logic        instr_valid;
    logic        reg_we;
    logic        swap_phase;
    logic        mem_we;
    logic        busy;
`ifdef SEQ_PERF_CNT_EN
    logic [15:0] retired;
`endif

    int nVectors = 0;
    int nErrors  = 0;

    exec_sequencer #(
        .PC_W(10),
        .START_PC(0),
        .MEM_LAT(3)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .Req(Req),
        .Ack(Ack),
        .prog_end(prog_end),
        .RegWrite_in(RegWrite_in),
        .MemWrite_in(MemWrite_in),
        .doSWAP_in(doSWAP_in),
        .load_in(load_in),
        .jump_en(jump_en),
        .target(target),
        .pc(pc),
        .instr_valid(instr_valid),
        .reg_we(reg_we),
        .swap_phase(swap_phase),
        .mem_we(mem_we),
`ifdef SEQ_PERF_CNT_EN
        .retired(retired),
`endif
        .busy(busy)
    );

    // 10 ns clock.
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic req, input logic regw, input logic memw,
                                 input logic swp, input logic ld, input logic jmp,
                                 input logic [9:0] tgt, input logic [9:0] pend);
        Req         = req;
        RegWrite_in = regw;
        MemWrite_in = memw;
        doSWAP_in   = swp;
        load_in     = ld;
        jump_en     = jmp;
        target      = tgt;
        prog_end    = pend;
    endtask

    task automatic stepClock();
        @(posedge Clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nVectors++;
        assert (obs === exp)
        else begin
            nErrors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Linear sequence of directed steps.
    initial begin
        Reset = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 10'h000, 10'h000);
        stepClock();
        stepClock();
        checkOutput("rst_pc", 32'(pc), 32'h000);
        checkOutput("rst_ack", 32'(Ack), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_ivalid", 32'(instr_valid), 0);
        checkOutput("rst_regwe", 32'(reg_we), 0);
        checkOutput("rst_memwe", 32'(mem_we), 0);
        checkOutput("rst_swap", 32'(swap_phase), 0);
        Reset = 1'b0;

        // Straight-line ALU program 0..3, Ack on cycle 7.
        applyStimulus(1, 1, 0, 0, 0, 0, 10'h000, 10'h003);
        stepClock();
        checkOutput("alu_c1_busy", 32'(busy), 1);
        checkOutput("alu_c1_pc", 32'(pc), 32'h000);
        checkOutput("alu_c1_ivalid", 32'(instr_valid), 0);
        stepClock();
        checkOutput("alu_c2_ivalid", 32'(instr_valid), 1);
        checkOutput("alu_c2_regwe", 32'(reg_we), 0);
        stepClock();
        checkOutput("alu_c3_pc", 32'(pc), 32'h001);
        checkOutput("alu_c3_regwe", 32'(reg_we), 1);
        stepClock();
        checkOutput("alu_c4_regwe", 32'(reg_we), 0);
        stepClock();
        checkOutput("alu_c5_pc", 32'(pc), 32'h002);
        checkOutput("alu_c5_regwe", 32'(reg_we), 1);
        stepClock();
        checkOutput("alu_c6_ack", 32'(Ack), 0);
        stepClock();
        checkOutput("alu_c7_pc", 32'(pc), 32'h003);
        checkOutput("alu_c7_ack", 32'(Ack), 1);
        checkOutput("alu_c7_busy", 32'(busy), 0);
        checkOutput("alu_c7_regwe", 32'(reg_we), 1);
        stepClock();
        checkOutput("alu_c8_ack", 32'(Ack), 1);
        checkOutput("alu_c8_regwe", 32'(reg_we), 0);
        Req = 1'b0;
        stepClock();
        checkOutput("alu_ack_clear", 32'(Ack), 0);
        checkOutput("alu_idle_pc", 32'(pc), 32'h003);

        // Reset held two cycles while in EXEC at pc=1.
        applyStimulus(1, 1, 0, 0, 0, 0, 10'h000, 10'h003);
        stepClock();
        stepClock();
        stepClock();
        stepClock();
        checkOutput("mrst_pre_ivalid", 32'(instr_valid), 1);
        checkOutput("mrst_pre_pc", 32'(pc), 32'h001);
        Reset = 1'b1;
        Req   = 1'b0;
        stepClock();
        checkOutput("mrst_c1_regwe", 32'(reg_we), 0);
        checkOutput("mrst_c1_pc", 32'(pc), 32'h000);
        stepClock();
        checkOutput("mrst_c2_regwe", 32'(reg_we), 0);
        checkOutput("mrst_c2_busy", 32'(busy), 0);
        checkOutput("mrst_c2_ack", 32'(Ack), 0);
        checkOutput("mrst_c2_ivalid", 32'(instr_valid), 0);
        Reset = 1'b0;

        // Jump to 5, load with MEM_LAT=3, jump to 2, SWAP, store, branch to prog_end.
        applyStimulus(1, 0, 0, 0, 0, 1, 10'h005, 10'h100);
        stepClock();
        stepClock();
        stepClock();
        checkOutput("ld_jump_pc", 32'(pc), 32'h005);
        applyStimulus(1, 1, 0, 0, 1, 0, 10'h000, 10'h100);
        stepClock();
        checkOutput("ld_exec_ivalid", 32'(instr_valid), 1);
        stepClock();
        checkOutput("ld_w1_regwe", 32'(reg_we), 0);
        checkOutput("ld_w1_busy", 32'(busy), 1);
        checkOutput("ld_w1_ivalid", 32'(instr_valid), 0);
        stepClock();
        checkOutput("ld_w2_regwe", 32'(reg_we), 0);
        stepClock();
        checkOutput("ld_w3_regwe", 32'(reg_we), 0);
        checkOutput("ld_w3_pc", 32'(pc), 32'h005);
        stepClock();
        checkOutput("ld_done_regwe", 32'(reg_we), 1);
        checkOutput("ld_done_pc", 32'(pc), 32'h006);
        applyStimulus(1, 0, 0, 0, 0, 1, 10'h002, 10'h100);
        stepClock();
        checkOutput("ld_after_regwe", 32'(reg_we), 0);
        stepClock();
        checkOutput("sw_jump_pc", 32'(pc), 32'h002);
        applyStimulus(1, 1, 0, 1, 0, 0, 10'h000, 10'h100);
        stepClock();
        checkOutput("sw_exec_regwe", 32'(reg_we), 0);
        stepClock();
        checkOutput("sw_p0_regwe", 32'(reg_we), 1);
        checkOutput("sw_p0_phase", 32'(swap_phase), 0);
        checkOutput("sw_p0_pc", 32'(pc), 32'h002);
        checkOutput("sw_p0_memwe", 32'(mem_we), 0);
        stepClock();
        checkOutput("sw_p1_regwe", 32'(reg_we), 1);
        checkOutput("sw_p1_phase", 32'(swap_phase), 1);
        checkOutput("sw_p1_pc", 32'(pc), 32'h003);
        checkOutput("sw_p1_memwe", 32'(mem_we), 0);
        applyStimulus(1, 0, 1, 0, 0, 0, 10'h000, 10'h100);
        stepClock();
        checkOutput("st_exec_memwe", 32'(mem_we), 0);
        checkOutput("st_exec_regwe", 32'(reg_we), 0);
        stepClock();
        checkOutput("st_memwe", 32'(mem_we), 1);
        checkOutput("st_regwe", 32'(reg_we), 0);
        checkOutput("st_pc", 32'(pc), 32'h004);
        applyStimulus(1, 0, 0, 0, 0, 1, 10'h100, 10'h100);
        stepClock();
        checkOutput("br_exec_memwe", 32'(mem_we), 0);
        stepClock();
        checkOutput("br_end_pc", 32'(pc), 32'h100);
        checkOutput("br_end_ack", 32'(Ack), 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 10'h000, 10'h100);
        stepClock();
        checkOutput("br_ack_clear", 32'(Ack), 0);

        // Branch near the top of the PC range, then wrap from 0x3FF to 0x000.
        applyStimulus(1, 0, 0, 0, 0, 1, 10'h3FF, 10'h010);
        stepClock();
        stepClock();
        stepClock();
        checkOutput("wr_pc_3ff", 32'(pc), 32'h3FF);
        applyStimulus(0, 0, 0, 0, 0, 1, 10'h3F0, 10'h010);
        stepClock();
        checkOutput("wr_req_ignored", 32'(busy), 1);
        stepClock();
        checkOutput("wr_branch_pc", 32'(pc), 32'h3F0);
        checkOutput("wr_branch_busy", 32'(busy), 1);
        applyStimulus(0, 0, 0, 0, 0, 1, 10'h3FF, 10'h010);
        stepClock();
        stepClock();
        checkOutput("wr_back_pc", 32'(pc), 32'h3FF);
        applyStimulus(1, 0, 0, 0, 0, 0, 10'h000, 10'h010);
        stepClock();
        stepClock();
        checkOutput("wr_wrap_pc", 32'(pc), 32'h000);
        checkOutput("wr_wrap_busy", 32'(busy), 1);
        checkOutput("wr_wrap_ack", 32'(Ack), 0);
        applyStimulus(1, 0, 0, 0, 0, 1, 10'h010, 10'h010);
        stepClock();
        stepClock();
        checkOutput("wr_end_pc", 32'(pc), 32'h010);
        checkOutput("wr_end_ack", 32'(Ack), 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 10'h000, 10'h010);
        stepClock();

        // prog_end equal to START_PC: first instruction must still run.
        applyStimulus(1, 1, 0, 0, 0, 0, 10'h000, 10'h000);
        stepClock();
        stepClock();
        stepClock();
        checkOutput("pe0_pc1", 32'(pc), 32'h001);
        checkOutput("pe0_busy", 32'(busy), 1);
        checkOutput("pe0_noack", 32'(Ack), 0);
        applyStimulus(1, 1, 0, 0, 0, 1, 10'h000, 10'h000);
        stepClock();
        stepClock();
        checkOutput("pe0_end_pc", 32'(pc), 32'h000);
        checkOutput("pe0_end_ack", 32'(Ack), 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 10'h000, 10'h000);
        stepClock();

`ifdef SEQ_PERF_CNT_EN
        // Four-instruction program: ALU, SWAP, load, ALU; decoder inputs follow pc.
        begin
            bit gotAck;
            gotAck = 1'b0;
            applyStimulus(1, 1, 0, 0, 0, 0, 10'h000, 10'h004);
            for (int cyc = 0; cyc < 40 && !gotAck; cyc++) begin
                RegWrite_in = 1'b1;
                doSWAP_in   = (pc == 10'h001);
                load_in     = (pc == 10'h002);
                stepClock();
                gotAck = Ack;
            end
            checkOutput("perf_ack", 32'(gotAck), 1);
            checkOutput("perf_retired", 32'(retired), 4);
            applyStimulus(0, 0, 0, 0, 0, 0, 10'h000, 10'h004);
            stepClock();
            checkOutput("perf_hold", 32'(retired), 4);
            Req = 1'b1;
            stepClock();
            checkOutput("perf_clear", 32'(retired), 0);
            Req = 1'b0;
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nErrors);
        $finish;
    end

endmodule
